chip_test_sequencer: RTL

- Front-end controller placed directly upstream of the per-chip tester blocks, such as the 74151 tester.
- Takes a debounced user Start and a chip selection, then pulses Run to exactly one tester.
- Waits for that tester's Done, captures its RSLT, and releases the tester with a one-cycle DISP_RSLT pulse.
- Holds pass, fail and timeout status for the LED and hex display logic downstream.

---
 rtl/chip_test_sequencer_pkg.sv | 24 ++
 rtl/chip_test_sequencer_start_conditioner.sv | 63 ++++++
 rtl/chip_test_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/chip_test_sequencer_pkg.sv
// Shared types and helpers for the chip test sequencer: FSM state encoding,
// default sizing constants and the one-hot tester-select mask generator.
package chip_test_pkg;

    typedef enum logic [2:0] {
        Idle,
        Launch,
        Wait,
        Settle,
        Capture,
        Release,
        Show
    } seq_state_t;

    localparam int N_CHIPS_DEF = 16;
    localparam int TIMEOUT_DEF = 16384;
    localparam int MASK_W      = 32;

    // Callers truncate the result to their own N_CHIPS width.
    function automatic logic [MASK_W-1:0] onehot(input logic [MASK_W-1:0] idx);
        return MASK_W'(1) << idx;
    endfunction

endpackage

// File: rtl/chip_test_sequencer_start_conditioner.sv
// Start conditioning: rising-edge detector on Start, optionally preceded by a
// 2-flop synchroniser and stability debouncer when START_DEBOUNCE_EN is defined.
module start_conditioner
#(
`ifdef START_DEBOUNCE_EN
    parameter int DEBOUNCE_CYCLES = 65536
`endif
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic start_pulse
);

`ifdef START_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);

    logic            sync1;
    logic            sync2;
    logic            level;
    logic            level_q;
    logic [DB_W-1:0] db_cnt;

    // The clean level follows the synchronised input only after it has
    // disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_q <= 1'b0;
            db_cnt  <= '0;
        end else begin
            sync1   <= start;
            sync2   <= sync1;
            level_q <= level;
            if (sync2 == level) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                level  <= sync2;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + DB_W'(1);
            end
        end
    end

    assign start_pulse = level & ~level_q;
`else
    logic start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= 1'b0;
        end else begin
            start_q <= start;
        end
    end

    assign start_pulse = start & ~start_q;
`endif

endmodule

// File: rtl/chip_test_sequencer.sv
// Launches one attached chip tester, waits for Done or timeout, captures RSLT
// and releases the tester. Optional START_DEBOUNCE_EN adds Start debouncing.
module chip_test_sequencer
    import chip_test_pkg::*;
#(
    parameter int N_CHIPS        = N_CHIPS_DEF,
    parameter int SEL_W          = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
`ifdef START_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 65536
`endif
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [SEL_W-1:0]   Chip_Sel,
    input  logic [N_CHIPS-1:0] Done_bus,
    input  logic [N_CHIPS-1:0] Rslt_bus,
    output logic [N_CHIPS-1:0] Run_bus,
    output logic [N_CHIPS-1:0] Disp_bus,
    output logic               Busy,
    output logic               Pass,
    output logic               Fail,
    output logic               Timeout,
    output logic               Sel_err,
    output logic [SEL_W-1:0]   Cur_chip
);

    localparam int                CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  TERM  = CNT_W'(TIMEOUT_CYCLES - 1);

    seq_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             start_pulse;
    logic             sel_ok;

`ifdef START_DEBOUNCE_EN
    start_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
        .clk        (Clk),
        .rst        (Reset),
        .start      (Start),
        .start_pulse(start_pulse)
    );
`else
    start_conditioner u_start (
        .clk        (Clk),
        .rst        (Reset),
        .start      (Start),
        .start_pulse(start_pulse)
    );
`endif

    assign sel_ok = (MASK_W'(Chip_Sel) < MASK_W'(N_CHIPS));

    // Run and Disp are cleared every cycle so each can only ever be a
    // single-cycle pulse; they are set in mutually exclusive states.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= Idle;
            cnt      <= '0;
            Run_bus  <= '0;
            Disp_bus <= '0;
            Busy     <= 1'b0;
            Pass     <= 1'b0;
            Fail     <= 1'b0;
            Timeout  <= 1'b0;
            Sel_err  <= 1'b0;
            Cur_chip <= '0;
        end else begin
            Run_bus  <= '0;
            Disp_bus <= '0;
            case (state)
                Idle, Show: begin
                    if (start_pulse) begin
                        if (sel_ok) begin
                            Cur_chip <= Chip_Sel;
                            Pass     <= 1'b0;
                            Fail     <= 1'b0;
                            Timeout  <= 1'b0;
                            Sel_err  <= 1'b0;
                            Run_bus  <= N_CHIPS'(onehot(MASK_W'(Chip_Sel)));
                            Busy     <= 1'b1;
                            state    <= Launch;
                        end else begin
                            Sel_err <= 1'b1;
                        end
                    end
                end
                Launch: begin
                    cnt   <= '0;
                    state <= Wait;
                end
                Wait: begin
                    // Done is tested first so it wins over the terminal count.
                    if (Done_bus[Cur_chip]) begin
                        state <= Settle;
                    end else if (cnt == TERM) begin
                        Timeout  <= 1'b1;
                        Fail     <= 1'b1;
                        Disp_bus <= N_CHIPS'(onehot(MASK_W'(Cur_chip)));
                        state    <= Release;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                Settle: begin
                    state <= Capture;
                end
                Capture: begin
                    Pass     <= Rslt_bus[Cur_chip];
                    Fail     <= ~Rslt_bus[Cur_chip];
                    Disp_bus <= N_CHIPS'(onehot(MASK_W'(Cur_chip)));
                    state    <= Release;
                end
                Release: begin
                    Busy  <= 1'b0;
                    state <= Show;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= Idle;
                end
            endcase
        end
    end

endmodule
